// File: rtl/sram_pkg.sv
// Shared definitions for the simple dual-port SRAM: read-during-write policy
// codes and the byte-enable merge used by both the array write and the bypass.
package sram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Upper bound on word width handled by be_merge; callers widen/truncate.
    localparam int MAX_BW_DATA = 256;
    localparam int MAX_BE      = MAX_BW_DATA / 8;

    function automatic int be_width(input int bw_data);
        return bw_data / 8;
    endfunction

    function automatic logic [MAX_BW_DATA-1:0] be_merge(
        input logic [MAX_BW_DATA-1:0] old_word,
        input logic [MAX_BW_DATA-1:0] new_word,
        input logic [MAX_BE-1:0]      be
    );
        logic [MAX_BW_DATA-1:0] res;
        for (int k = 0; k < MAX_BE; k++) begin
            res[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sdpsram_be_if.sv
// Write/read port bundle of the simple dual-port SRAM.
interface sdpsram_be_if #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5
);
    logic                   i_wr_en;
    logic [BW_ADDR-1:0]     i_wr_addr;
    logic [BW_DATA-1:0]     i_wr_data;
    logic [BW_DATA/8-1:0]   i_wr_be;
    logic                   i_rd_en;
    logic [BW_ADDR-1:0]     i_rd_addr;
    logic [BW_DATA-1:0]     o_rd_data;
    logic                   o_rd_valid;
    logic                   o_rd_err;
    logic                   o_wr_err;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_wr_be, i_rd_en, i_rd_addr,
        input  o_rd_data, o_rd_valid, o_rd_err, o_wr_err
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_wr_be, i_rd_en, i_rd_addr,
        output o_rd_data, o_rd_valid, o_rd_err, o_wr_err
    );

endinterface

// File: rtl/sram_pipe_reg.sv
// One read-pipeline stage {valid, err, data}; data holds between reads so the
// output never returns to an undefined value.
module sram_pipe_reg #(
    parameter int BW_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_valid,
    input  logic               i_err,
    input  logic [BW_DATA-1:0] i_data,
    output logic               o_valid,
    output logic               o_err,
    output logic [BW_DATA-1:0] o_data
);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= i_valid;
            o_err   <= i_valid & i_err;
            if (i_valid) begin
                o_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/sdpsram_be.sv
// Simple dual-port SRAM: one byte-enabled write port, one read port with
// 1- or 2-cycle registered read and selectable read-during-write behaviour.
module sdpsram_be
    import sram_pkg::*;
#(
    parameter int BW_DATA  = 32,
    parameter int BW_ADDR  = 5,
    parameter int DEPTH    = 2**BW_ADDR,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = RDW_OLD
) (
    input logic        i_clk,
    input logic        i_rstn,
    sdpsram_be_if.slave bus
);

    localparam int               BW_BE   = be_width(BW_DATA);
    localparam logic [BW_ADDR:0] DEPTH_W = (BW_ADDR+1)'(DEPTH);

    if (BW_DATA % 8 != 0) begin : g_chk_bw
        $error("sdpsram_be: BW_DATA must be a multiple of 8");
    end
    if (BW_DATA > MAX_BW_DATA) begin : g_chk_max
        $error("sdpsram_be: BW_DATA exceeds MAX_BW_DATA");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_lat
        $error("sdpsram_be: RD_LAT must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > 2**BW_ADDR) begin : g_chk_depth
        $error("sdpsram_be: DEPTH out of range for BW_ADDR");
    end

    logic [BW_DATA-1:0] mem [DEPTH];

    logic               wr_in_range;
    logic               rd_in_range;
    logic               wr_do;
    logic               bypass;
    logic [BW_DATA-1:0] wr_old;
    logic [BW_DATA-1:0] wr_merged;
    logic [BW_DATA-1:0] rd_word;
    logic [BW_BE-1:0]   wr_be;

    logic               s1_valid;
    logic               s1_err;
    logic [BW_DATA-1:0] s1_data;

    assign wr_be       = bus.i_wr_be;
    assign wr_in_range = {1'b0, bus.i_wr_addr} < DEPTH_W;
    assign rd_in_range = {1'b0, bus.i_rd_addr} < DEPTH_W;
    assign wr_do       = bus.i_wr_en & wr_in_range;
    // Same-edge collision forwards the merged word only in write-through mode.
    assign bypass      = (RDW_MODE == RDW_NEW) && wr_do &&
                         (bus.i_wr_addr == bus.i_rd_addr);

    always_comb begin
        wr_old = '0;
        if (wr_in_range) begin
            wr_old = mem[bus.i_wr_addr];
        end
        wr_merged = BW_DATA'(be_merge(MAX_BW_DATA'(wr_old),
                                      MAX_BW_DATA'(bus.i_wr_data),
                                      MAX_BE'(wr_be)));
    end

    always_ff @(posedge i_clk) begin
        if (wr_do) begin
            mem[bus.i_wr_addr] <= wr_merged;
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = bypass ? wr_merged : mem[bus.i_rd_addr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bus.o_wr_err <= 1'b0;
        end else begin
            bus.o_wr_err <= bus.i_wr_en & ~wr_in_range;
        end
    end

    sram_pipe_reg #(.BW_DATA(BW_DATA)) u_stage1 (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (bus.i_rd_en),
        .i_err   (~rd_in_range),
        .i_data  (rd_word),
        .o_valid (s1_valid),
        .o_err   (s1_err),
        .o_data  (s1_data)
    );

    if (RD_LAT == 2) begin : g_stage2
        sram_pipe_reg #(.BW_DATA(BW_DATA)) u_stage2 (
            .i_clk   (i_clk),
            .i_rstn  (i_rstn),
            .i_valid (s1_valid),
            .i_err   (s1_err),
            .i_data  (s1_data),
            .o_valid (bus.o_rd_valid),
            .o_err   (bus.o_rd_err),
            .o_data  (bus.o_rd_data)
        );
    end else begin : g_no_stage2
        assign bus.o_rd_valid = s1_valid;
        assign bus.o_rd_err   = s1_err;
        assign bus.o_rd_data  = s1_data;
    end

endmodule

// File: tb/tb_sdpsram_be.sv
// Scoreboard bench: two SRAM configurations share one random/directed stimulus
// stream; a reference model predicts each read and write-error event.
module tb_sdpsram_be;

    localparam int BW_DATA = 32;
    localparam int BW_ADDR = 5;
    localparam int ND      = 2;
    localparam int DEP  [ND] = '{20, 32};
    localparam int LAT  [ND] = '{1, 2};
    localparam int MODE [ND] = '{0, 1};

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;

    logic [31:0] rd_data  [ND];
    logic        rd_valid [ND];
    logic        rd_err   [ND];
    logic        wr_err   [ND];

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        end_req = 1'b0;
    logic        end_done = 1'b0;

    logic [31:0] mdl  [ND][32];
    logic [31:0] last [ND];
    exp_t        rq   [ND][$];
    int          wq   [ND][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sdpsram_be_if #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) bus ();
        sdpsram_be #(
            .BW_DATA  (BW_DATA),
            .BW_ADDR  (BW_ADDR),
            .DEPTH    (DEP[g]),
            .RD_LAT   (LAT[g]),
            .RDW_MODE (MODE[g])
        ) dut (
            .i_clk  (clk),
            .i_rstn (rstn),
            .bus    (bus)
        );
        assign bus.i_wr_en   = wr_en;
        assign bus.i_wr_addr = wr_addr;
        assign bus.i_wr_data = wr_data;
        assign bus.i_wr_be   = wr_be;
        assign bus.i_rd_en   = rd_en;
        assign bus.i_rd_addr = rd_addr;
        assign rd_data[g]    = bus.o_rd_data;
        assign rd_valid[g]   = bus.o_rd_valid;
        assign rd_err[g]     = bus.o_rd_err;
        assign wr_err[g]     = bus.o_wr_err;
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc%0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    // Drive one cycle of port activity and predict its outcome in every model.
    task automatic issue(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic re, input logic [4:0] ra);
        @(posedge clk);
        #1;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        for (int d = 0; d < ND; d++) begin
            if (re) begin
                exp_t e;
                e.due = cyc + LAT[d];
                if (int'(ra) >= DEP[d]) begin
                    e.data = '0;
                    e.err  = 1'b1;
                end else begin
                    e.err  = 1'b0;
                    e.data = mdl[d][ra];
                    if (MODE[d] == 1 && we && wa == ra) e.data = merge(mdl[d][ra], wd, be);
                end
                rq[d].push_back(e);
            end
            if (we) begin
                if (int'(wa) >= DEP[d]) wq[d].push_back(cyc + 1);
                else mdl[d][wa] = merge(mdl[d][wa], wd, be);
            end
        end
    endtask

    task automatic idle();
        issue(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            logic exp_v;
            logic exp_w;
            exp_t e;
            if (!rstn) begin
                check("rst_data",  d, rd_data[d], 32'h0);
                check("rst_valid", d, 32'(rd_valid[d]), 32'h0);
                check("rst_rd_err", d, 32'(rd_err[d]), 32'h0);
                check("rst_wr_err", d, 32'(wr_err[d]), 32'h0);
                rq[d].delete();
                wq[d].delete();
                last[d] = '0;
            end else begin
                exp_w = (wq[d].size() > 0) && (wq[d][0] == cyc);
                if (exp_w) void'(wq[d].pop_front());
                check("wr_err", d, 32'(wr_err[d]), 32'(exp_w));
                exp_v = (rq[d].size() > 0) && (rq[d][0].due == cyc);
                check("rd_valid", d, 32'(rd_valid[d]), 32'(exp_v));
                if (exp_v) begin
                    e = rq[d].pop_front();
                    if (rd_valid[d]) begin
                        check("rd_data", d, rd_data[d], e.data);
                        check("rd_err",  d, 32'(rd_err[d]), 32'(e.err));
                    end
                    last[d] = e.data;
                end else if (!rd_valid[d]) begin
                    check("rd_hold", d, rd_data[d], last[d]);
                    check("rd_err_idle", d, 32'(rd_err[d]), 32'h0);
                end
            end
        end
        if (end_req && !end_done) begin
            for (int d = 0; d < ND; d++) begin
                check("rd_left", d, 32'(rq[d].size()), 32'h0);
                check("wr_left", d, 32'(wq[d].size()), 32'h0);
            end
            end_done = 1'b1;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        for (int a = 0; a < 32; a++) issue(1'b1, 5'(a), $urandom, 4'hF, 1'b0, '0);

        // byte-enable merge
        issue(1'b1, 5'd3, 32'hAABBCCDD, 4'b1111, 1'b0, '0);
        issue(1'b1, 5'd3, 32'h11223344, 4'b0101, 1'b0, '0);
        issue(1'b0, '0, '0, '0, 1'b1, 5'd3);
        // full and partial collisions on addr 7
        issue(1'b1, 5'd7, 32'h0, 4'hF, 1'b0, '0);
        issue(1'b1, 5'd7, 32'hDEADBEEF, 4'hF, 1'b1, 5'd7);
        issue(1'b0, '0, '0, '0, 1'b1, 5'd7);
        issue(1'b1, 5'd7, 32'h12345678, 4'hF, 1'b0, '0);
        issue(1'b1, 5'd7, 32'hFFFFFFFF, 4'b0011, 1'b1, 5'd7);
        issue(1'b0, '0, '0, '0, 1'b1, 5'd7);
        // out-of-range access must not alias onto low words
        issue(1'b1, 5'd5, 32'h05050505, 4'hF, 1'b0, '0);
        issue(1'b1, 5'd9, 32'h09090909, 4'hF, 1'b0, '0);
        issue(1'b1, 5'd25, 32'hCAFEF00D, 4'hF, 1'b0, '0);
        issue(1'b0, '0, '0, '0, 1'b1, 5'd25);
        issue(1'b0, '0, '0, '0, 1'b1, 5'd5);
        issue(1'b0, '0, '0, '0, 1'b1, 5'd9);
        idle();
        idle();
        // streaming reads
        for (int a = 0; a < 8; a++) issue(1'b0, '0, '0, '0, 1'b1, 5'(a));
        idle();
        idle();
        idle();
        // reset with reads in flight
        issue(1'b0, '0, '0, '0, 1'b1, 5'd1);
        issue(1'b0, '0, '0, '0, 1'b1, 5'd2);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) idle();
        for (int a = 0; a < 32; a++) issue(1'b0, '0, '0, '0, 1'b1, 5'(a));

        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa;
            logic [4:0] ra;
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            issue(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), ra);
        end

        repeat (4) idle();
        end_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdpsram_be.md
# sdpsram_be

Simple dual-port synchronous SRAM with one write port and one read port. Both ports can operate in the same cycle. Writes use per-byte enables. The read path has a parameterised pipeline depth with a valid flag, and the read-during-write policy on an address collision is selectable. This block is the memory primitive for FIFOs, line buffers and register-file style storage that need concurrent read and write with deterministic, reset-defined outputs.

## Interface
Parameters:
- BW_DATA, 32, data width; must be a multiple of 8
- BW_ADDR, 5, address width
- DEPTH, 2**BW_ADDR, number of words; must satisfy 1 ≤ DEPTH ≤ 2**BW_ADDR
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- RDW_MODE, 0, read-during-write policy: 0 = old data, 1 = new data (write-through bypass)

Ports (one clock; reset is asynchronous and active-low):
- i_clk  input  1  clock, rising edge
- i_rstn  input  1  asynchronous active-low reset
- i_wr_en  input  1  write request
- i_wr_addr  input  BW_ADDR  write address
- i_wr_data  input  BW_DATA  write data
- i_wr_be  input  BW_DATA/8  byte enables; bit k enables byte [8k+7:8k]
- i_rd_en  input  1  read request
- i_rd_addr  input  BW_ADDR  read address
- o_rd_data  output  BW_DATA  read data
- o_rd_valid  output  1  o_rd_data holds the result of a read
- o_rd_err  output  1  the read at this position addressed a word ≥ DEPTH
- o_wr_err  output  1  registered flag: the previous-cycle write addressed a word ≥ DEPTH

## Operation
- Write: on a rising edge with i_wr_en=1 and i_wr_addr<DEPTH, only the bytes whose i_wr_be bit is 1 are updated. i_wr_be=0 is a legal no-op.
- A write with i_wr_addr≥DEPTH leaves the array unchanged and sets o_wr_err=1 for one cycle.
- Read: on a rising edge with i_rd_en=1, the addressed word is captured into the read pipeline.
- A read with i_rd_addr≥DEPTH returns all-zero data with o_rd_err=1 and o_rd_valid=1.
- Collision (i_wr_en and i_rd_en both 1, same in-range address, same edge):
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the merged word, i.e. new bytes where i_wr_be=1 and old bytes elsewhere.
- With no read in flight, o_rd_data holds its last value. It never goes X or Z. o_rd_valid deasserts.
- Reset clears only o_rd_data, o_rd_valid, o_rd_err, o_wr_err and all pipeline stages. The array is not reset; its contents are undefined until written.
- Reset asserted mid-pipeline drops every in-flight read; no valid pulse appears after reset release.

## Timing
- Reset values: o_rd_data=0, o_rd_valid=0, o_rd_err=0, o_wr_err=0.
- RD_LAT=1: a read sampled at edge N gives data/valid/err after edge N, visible in cycle N+1.
- RD_LAT=2: the same read is visible after edge N+1.
- Throughput is one read and one write per cycle at either latency. Back-to-back reads give continuous o_rd_valid.
- Write data is visible to a read sampled at edge N+1 or later, in both RDW_MODE settings.
- With RD_LAT=2, a write at edge N+1 does not alter a read already captured at edge N.
- o_wr_err is asserted in the cycle after the offending edge.

## Structure
- Shared package sram_pkg holds:
  - localparams RDW_OLD=0 and RDW_NEW=1
  - function be_width(bw_data)=bw_data/8
  - a function that merges a byte-enabled write onto an old word. It is used by both the array write and the RDW_NEW bypass.
- Sub-module sram_pipe_reg is a reset-clearable stage carrying {valid, err, data}. It is instantiated RD_LAT times. Stage 1 captures the array or bypass result; stage 2 is optional.
- The array is an unreset reg array of DEPTH words.
- Elaboration-time checks reject BW_DATA%8≠0, RD_LAT∉{1,2} and DEPTH>2**BW_ADDR.

## Test plan
- Byte-enable write, defaults:
  - Write addr 3 with data 0xAABBCCDD, be=4'b1111, then addr 3 with data 0x11223344, be=4'b0101.
  - Read addr 3 → o_rd_data=0xAA22CC44 one cycle after the read edge, with o_rd_valid=1.
- Collision, RDW_MODE=0:
  - Preload addr 7 with 0x0; same edge write 0xDEADBEEF (be=4'hF) and read addr 7.
  - → 0x00000000; the next read of addr 7 → 0xDEADBEEF.
- Collision, RDW_MODE=1 with partial enable:
  - Preload addr 7 with 0x12345678; same edge write 0xFFFFFFFF with be=4'b0011 and read addr 7.
  - → 0x1234FFFF.
- Out of range, DEPTH=20:
  - Write addr 25 → o_wr_err=1 for one cycle and the array is unchanged.
  - Read addr 25 → o_rd_data=0, o_rd_err=1, o_rd_valid=1.
- RD_LAT=2 streaming:
  - Reads of addr 0..7 on consecutive edges → o_rd_valid high for exactly 8 consecutive cycles, starting two edges after the first read, with data in order.
- Reset mid-operation, RD_LAT=2:
  - Assert i_rstn=0 between two edges while 2 reads are in flight → all outputs 0 immediately.
  - After release, no o_rd_valid pulse appears and the array contents are preserved.
